// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// 640x480@60 raster generator: pixel divider, h/v counters, registered syncs
// and active-video flag, plus line/frame end strobes for blanking-time updates.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
  localparam logic [9:0]    HMAX = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VMAX = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync pulse ending exactly at 1024 still compares right
  localparam logic [10:0]   HS_B = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_E = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_B = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_E = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0]   HA   = 11'(H_ACTIVE);
  localparam logic [10:0]   VA   = 11'(V_ACTIVE);

  logic [DW-1:0] div;
  logic [9:0]    hcnt, vcnt;
  logic [9:0]    h_nxt, v_nxt;
  logic          h_wrap, v_wrap;
  logic          hs_nxt, vs_nxt, vo_nxt;

  assign pix_tick  = (div == DMAX);
  assign x         = hcnt;
  assign y         = vcnt;
  assign line_end  = pix_tick && h_wrap;
  assign frame_end = line_end && v_wrap;

  // Sync/active flags are computed from the counter values about to be loaded,
  // so the registered outputs always agree with the registered x/y.
  always_comb begin
    h_wrap = (hcnt == HMAX);
    v_wrap = (vcnt == VMAX);
    h_nxt  = h_wrap ? '0 : hcnt + 10'd1;
    v_nxt  = vcnt;
    if (h_wrap) v_nxt = v_wrap ? '0 : vcnt + 10'd1;
    hs_nxt = ({1'b0, h_nxt} >= HS_B) && ({1'b0, h_nxt} < HS_E);
    vs_nxt = ({1'b0, v_nxt} >= VS_B) && ({1'b0, v_nxt} < VS_E);
    vo_nxt = ({1'b0, h_nxt} < HA) && ({1'b0, v_nxt} < VA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b1;
    end else begin
      div <= pix_tick ? '0 : div + 1'b1;
      if (pix_tick) begin
        hcnt     <= h_nxt;
        vcnt     <= v_nxt;
        hsync    <= hs_nxt ? SYNC_POL : ~SYNC_POL;
        vsync    <= vs_nxt ? SYNC_POL : ~SYNC_POL;
        video_on <= vo_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Directed bench: default raster (line timing), CLK_DIV=1/active-high variant,
// and a shrunken raster checked clock-by-clock across two frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A: default parameters
  logic rst_a;
  logic [9:0] xa, ya;
  logic hsa, vsa, voa, pta, lea, fea;
  vga_timing_gen u_a (.clk(clk), .rst(rst_a), .x(xa), .y(ya), .hsync(hsa), .vsync(vsa),
    .video_on(voa), .pix_tick(pta), .line_end(lea), .frame_end(fea));

  // C: one clock per pixel, active-high syncs
  logic rst_c;
  logic [9:0] xc, yc;
  logic hsc, vsc, voc, ptc, lec, fec;
  vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_c (.clk(clk), .rst(rst_c), .x(xc), .y(yc),
    .hsync(hsc), .vsync(vsc), .video_on(voc), .pix_tick(ptc), .line_end(lec), .frame_end(fec));

  // B: small raster, H_TOTAL=32, V_TOTAL=17, 3 clks per pixel
  logic rst_b;
  logic [9:0] xb, yb;
  logic hsb, vsb, vob, ptb, leb, feb;
  vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_b (.clk(clk), .rst(rst_b), .x(xb), .y(yb),
    .hsync(hsb), .vsync(vsb), .video_on(vob), .pix_tick(ptb), .line_end(leb), .frame_end(feb));

  logic [25:0] got_b;
  assign got_b = {xb, yb, hsb, vsb, vob, ptb, leb, feb};
  localparam logic [25:0] RST_B = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Reference for B: k clock edges after reset release -> pixel index k/3
  function automatic logic [25:0] ref_b(input int k);
    int p, px, py;
    logic hs, vs, vo, pt, le, fe;
    p  = k / 3;
    px = p % 32;
    py = (p / 32) % 17;
    hs = !(px >= 23 && px < 27);
    vs = !(py >= 12 && py < 14);
    vo = (px < 20) && (py < 10);
    pt = (k % 3) == 2;
    le = pt && (px == 31);
    fe = le && (py == 16);
    return {px[9:0], py[9:0], hs, vs, vo, pt, le, fe};
  endfunction

  initial begin
    int le1, le2, hs_low, hs_first, vo_first, x_at_vo, y_line1, x_line1, fe_seen;
    int c_pt0, c_le1, c_le2, c_hs_hi, c_hs_first, c_x1;
    int fe1, fe2, vs_low, vo_cnt, wait_n;
    bit injected;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_rst_x", xa, 0);            chk("a_rst_y", ya, 0);
    chk("a_rst_hs", hsa, 1);          chk("a_rst_vs", vsa, 1);
    chk("a_rst_vo", voa, 1);          chk("a_rst_pt", pta, 0);
    chk("c_rst_pt", ptc, 1);          chk("c_rst_hs", hsc, 0);
    chk("c_rst_vs", vsc, 0);          chk("b_rst", got_b, RST_B);

    // A: release, first increment after CLK_DIV clocks, then two lines
    rst_a = 1'b0;
    le1 = -1; le2 = -1; hs_low = 0; hs_first = -1; vo_first = -1;
    x_at_vo = -1; y_line1 = -1; x_line1 = -1; fe_seen = 0;
    for (int k = 1; k <= 6400; k++) begin
      @(negedge clk);
      if (k == 3) begin chk("a_x_k3", xa, 0); chk("a_pt_k3", pta, 1); end
      if (k == 4) chk("a_x_k4", xa, 1);
      if (lea && le1 < 0) le1 = k;
      else if (lea && le2 < 0) le2 = k;
      if (k <= 3200 && !hsa) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (!voa && vo_first < 0) begin vo_first = k; x_at_vo = xa; end
      if (k == 3200) begin y_line1 = ya; x_line1 = xa; end
      if (fea) fe_seen++;
    end
    chk("a_le_first", le1, 3199);
    chk("a_le_period", le2 - le1, 3200);
    chk("a_hs_low_clks", hs_low, 384);
    chk("a_hs_first_low", hs_first, 2624);
    chk("a_vo_drop_clk", vo_first, 2560);
    chk("a_vo_drop_x", x_at_vo, 640);
    chk("a_line1_y", y_line1, 1);
    chk("a_line1_x", x_line1, 0);
    chk("a_no_frame_end", fe_seen, 0);

    // A: asynchronous reset mid-line, held for several clocks
    wait_n = $urandom_range(1, 500);
    repeat (wait_n) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("a_async_x", xa, 0);  chk("a_async_y", ya, 0);
    chk("a_async_hs", hsa, 1); chk("a_async_vo", voa, 1);
    repeat (4) @(negedge clk);
    chk("a_hold_x", xa, 0);   chk("a_hold_pt", pta, 0);
    rst_a = 1'b0;

    // C: released after an arbitrary delay
    wait_n = $urandom_range(1, 40);
    repeat (wait_n) @(negedge clk);
    rst_c = 1'b0;
    c_pt0 = 0; c_le1 = -1; c_le2 = -1; c_hs_hi = 0; c_hs_first = -1; c_x1 = -1;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (k == 1) c_x1 = xc;
      if (!ptc) c_pt0++;
      if (lec && c_le1 < 0) c_le1 = k;
      else if (lec && c_le2 < 0) c_le2 = k;
      if (k <= 800 && hsc) begin
        c_hs_hi++;
        if (c_hs_first < 0) c_hs_first = k;
      end
    end
    chk("c_first_inc", c_x1, 1);
    chk("c_pt_low_clks", c_pt0, 0);
    chk("c_le_first", c_le1, 799);
    chk("c_le_period", c_le2 - c_le1, 800);
    chk("c_hs_hi_clks", c_hs_hi, 96);
    chk("c_hs_first_hi", c_hs_first, 656);

    // B: per-clock model compare, reset injected mid-line at x=25,y=6
    rst_b = 1'b0;
    injected = 1'b0;
    for (int k = 1; k <= 2000 && !injected; k++) begin
      @(negedge clk);
      chk("b_sb_pre", got_b, ref_b(k));
      if (k == 651) begin
        chk("b_inject_x", xb, 25);
        chk("b_inject_y", yb, 6);
        rst_b = 1'b1;
        #1;
        chk("b_async", got_b, RST_B);
        injected = 1'b1;
      end
    end
    chk("b_injected", injected, 1);
    repeat (2) @(negedge clk);
    chk("b_hold", got_b, RST_B);
    rst_b = 1'b0;
    fe1 = -1; fe2 = -1; vs_low = 0; vo_cnt = 0;
    for (int k = 1; k <= 3266; k++) begin
      @(negedge clk);
      chk("b_sb", got_b, ref_b(k));
      if (feb && fe1 < 0) fe1 = k;
      else if (feb && fe2 < 0) fe2 = k;
      if (k <= 1632) begin
        if (!vsb) vs_low++;
        if (vob) vo_cnt++;
      end
      if (k == 1632) begin chk("b_wrap_x", xb, 0); chk("b_wrap_y", yb, 0); end
    end
    chk("b_fe_first", fe1, 1631);
    chk("b_fe_period", fe2 - fe1, 1632);
    chk("b_vs_low_clks", vs_low, 192);
    chk("b_vo_clks", vo_cnt, 600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
